// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types for the hazard scoreboard.
// Slot record, register-address width and forward-select encodings.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/hazard_match.sv
// Per-source youngest-match search over the in-flight slots.
// Purely combinational; yields a forward select and a load-not-ready flag.
module hazard_match
  import riscv_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int LOAD_READY = 1,
  parameter int FWD_W = $clog2(DEPTH + 1)
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  slot_t [DEPTH-1:0]     slots,
  output logic [FWD_W-1:0]      fwd_sel,
  output logic                  unready
);

  logic hit;

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_sel = FWD_W'(FWD_RF);
    unready = 1'b0;
    hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hit = slots[k].valid && slots[k].regwrite &&
            (slots[k].rd == rs) && (rs != '0);
      if (hit) begin
        if (!slots[k].is_load || k >= LOAD_READY) begin
          fwd_sel = FWD_W'(k + 1);
          unready = 1'b0;
        end else begin
          fwd_sel = FWD_W'(FWD_RF);
          unready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard with forwarding selects and load-use stall.
// Define HAZARD_PERF_EN to enable the saturating stall-cycle counter.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int NUM_SRC = 2,
  parameter int LOAD_READY = 1,
  parameter int FWD_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic                          issue_regwrite,
  input  logic                          issue_is_load,
  input  logic [REG_ADDR_W*NUM_SRC-1:0] issue_rs,
  input  logic                          flush,
  output logic                          stall,
  output logic [FWD_W*NUM_SRC-1:0]      fwd_sel,
  output logic [31:0]                   pipeline_stall_cnt
);

  slot_t [DEPTH-1:0] slots;
  slot_t             issued;
  logic [NUM_SRC-1:0] unready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_match #(
      .DEPTH(DEPTH),
      .LOAD_READY(LOAD_READY),
      .FWD_W(FWD_W)
    ) u_match (
      .rs(issue_rs[REG_ADDR_W*i +: REG_ADDR_W]),
      .slots(slots),
      .fwd_sel(fwd_sel[FWD_W*i +: FWD_W]),
      .unready(unready[i])
    );
  end

  // Built only from match flags, never from fwd_sel.
  assign stall = issue_valid && !flush && (|unready);

  always_comb begin
    issued = '0;
    issued.valid = issue_valid && !stall && !flush;
    issued.rd = issue_rd;
    issued.regwrite = issue_regwrite;
    issued.is_load = issue_is_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slots <= '0;
    end else begin
      slots[0] <= issued;
      for (int k = 1; k < DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (stall && cnt != 32'hFFFF_FFFF) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign pipeline_stall_cnt = cnt;
`else
  assign pipeline_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vectors,
// a slot-list reference model and hand-computed literal expectations.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int NUM_SRC = 2;
  localparam int LOAD_READY = 1;
  localparam int FWD_W = 2;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_regwrite;
  logic        issue_is_load;
  logic [9:0]  issue_rs;
  logic        flush;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [31:0] pipeline_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .DEPTH(DEPTH),
    .NUM_SRC(NUM_SRC),
    .LOAD_READY(LOAD_READY),
    .FWD_W(FWD_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite),
    .issue_is_load(issue_is_load),
    .issue_rs(issue_rs),
    .flush(flush),
    .stall(stall),
    .fwd_sel(fwd_sel),
    .pipeline_stall_cnt(pipeline_stall_cnt)
  );

  // Model: list of in-flight instructions, index 0 = youngest.
  bit          m_valid [DEPTH] = '{default: 1'b0};
  logic [4:0]  m_rd    [DEPTH] = '{default: 5'd0};
  bit          m_rw    [DEPTH] = '{default: 1'b0};
  bit          m_ld    [DEPTH] = '{default: 1'b0};
  longint      m_cnt = 0;
  bit          seen_reset = 1'b0;

  function automatic int youngest(input logic [4:0] rs);
    if (rs == 5'd0) return -1;
    for (int k = 0; k < DEPTH; k++)
      if (m_valid[k] && m_rw[k] && m_rd[k] == rs) return k;
    return -1;
  endfunction

  function automatic int exp_sel(input logic [4:0] rs);
    int k;
    k = youngest(rs);
    if (k < 0) return 0;
    if (m_ld[k] && k < LOAD_READY) return 0;
    return k + 1;
  endfunction

  function automatic bit exp_stall();
    int k;
    if (!issue_valid || flush) return 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      k = youngest(issue_rs[5*s +: 5]);
      if (k >= 0 && m_ld[k] && k < LOAD_READY) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = exp_stall();
    if (reset) begin
      seen_reset <= 1'b1;
      m_cnt <= 0;
      for (int k = 0; k < DEPTH; k++) m_valid[k] <= 1'b0;
    end else begin
      if (PERF && st && m_cnt < 64'hFFFF_FFFF) m_cnt <= m_cnt + 1;
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_valid[k] <= m_valid[k-1];
        m_rd[k] <= m_rd[k-1];
        m_rw[k] <= m_rw[k-1];
        m_ld[k] <= m_ld[k-1];
      end
      m_valid[0] <= issue_valid && !st && !flush;
      m_rd[0] <= issue_rd;
      m_rw[0] <= issue_regwrite;
      m_ld[0] <= issue_is_load;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (seen_reset) begin
      chk("model_stall", stall, exp_stall());
      chk("model_fwd0", fwd_sel[1:0], exp_sel(issue_rs[4:0]));
      chk("model_fwd1", fwd_sel[3:2], exp_sel(issue_rs[9:5]));
      chk("model_cnt", pipeline_stall_cnt, m_cnt);
    end
  end

  task automatic step(input bit v, input logic [4:0] rd, input bit rw,
                      input bit ld, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit fl, input bit rst);
    @(posedge clk);
    #1;
    issue_valid = v;
    issue_rd = rd;
    issue_regwrite = rw;
    issue_is_load = ld;
    issue_rs = {rs2, rs1};
    flush = fl;
    reset = rst;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0;
    issue_rd = '0;
    issue_regwrite = 1'b0;
    issue_is_load = 1'b0;
    issue_rs = '0;
    flush = 1'b0;
    @(posedge clk);
    @(posedge clk);

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd", fwd_sel, 0);
    chk("rst_cnt", pipeline_stall_cnt, 0);

    // ALU result forwarded from slot 0
    step(1, 5, 1, 0, 1, 2, 0, 0);
    step(1, 8, 1, 0, 5, 0, 0, 0);
    chk("alu_fwd0", fwd_sel[1:0], 1);
    chk("alu_stall", stall, 0);

    // Load-use: one stall, then forward from slot 1
    step(1, 6, 1, 1, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 6, 0, 0);
    chk("lu_stall", stall, 1);
    chk("lu_fwd1_0", fwd_sel[3:2], 0);
    step(1, 9, 1, 0, 0, 6, 0, 0);
    chk("lu_stall_done", stall, 0);
    chk("lu_fwd1_2", fwd_sel[3:2], 2);

    // Youngest of two writers wins
    step(1, 7, 1, 0, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 0, 0);
    step(1, 4, 1, 0, 7, 0, 0, 0);
    chk("young_fwd0", fwd_sel[1:0], 1);

    // x0 never matches
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0, 0);
    chk("x0_fwd0", fwd_sel[1:0], 0);
    chk("x0_stall", stall, 0);

    // Flush masks the stall and bubbles slot 0
    step(1, 10, 1, 1, 0, 0, 0, 0);
    step(1, 11, 1, 0, 10, 0, 1, 0);
    chk("fl_stall", stall, 0);
    step(1, 1, 1, 0, 11, 10, 0, 0);
    chk("fl_slot0_fwd0", fwd_sel[1:0], 0);
    chk("fl_load_fwd1", fwd_sel[3:2], 2);
    chk("fl_after_stall", stall, 0);

    // Three load-use stalls, then reset clears the counter
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(1, 13, 1, 1, 0, 0, 0, 0);
      step(1, 14, 1, 0, 13, 0, 0, 0);
      step(1, 14, 1, 0, 13, 0, 0, 0);
    end
    chk("perf_cnt3", pipeline_stall_cnt, PERF ? 3 : 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("perf_cnt0", pipeline_stall_cnt, 0);

    // Reset during an active stall drops the hazard
    step(1, 12, 1, 1, 0, 0, 0, 0);
    step(1, 15, 1, 0, 12, 0, 0, 1);
    chk("rs_stall_pre", stall, 1);
    step(1, 15, 1, 0, 12, 0, 0, 0);
    chk("rs_stall_post", stall, 0);
    chk("rs_fwd0", fwd_sel[1:0], 0);
    chk("rs_cnt", pipeline_stall_cnt, 0);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning in-flight pipeline slots tracked after issue (EX, MEM, WB).
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning source operands checked per issued instruction.
REQ-003 SHALL have parameter LOAD_READY, default 1, meaning the first slot index whose load data can be forwarded.
REQ-004 SHALL have parameter FWD_W, default $clog2(DEPTH+1), meaning the width of each forward select.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-007 SHALL have port issue_valid  input  1  meaning an instruction is presented for issue this cycle.
REQ-008 SHALL have port issue_rd  input  5  meaning the destination register of that instruction.
REQ-009 SHALL have port issue_regwrite  input  1  meaning that instruction writes issue_rd.
REQ-010 SHALL have port issue_is_load  input  1  meaning that instruction is a load.
REQ-011 SHALL have port issue_rs  input  5*NUM_SRC  meaning packed source registers, src i at [5i+4:5i].
REQ-012 SHALL have port flush  input  1  meaning kill the issuing instruction and slot 0.
REQ-013 SHALL have port stall  output  1  meaning hold the issue stage; the consumer does not advance.
REQ-014 SHALL have port fwd_sel  output  FWD_W*NUM_SRC  meaning per-source select: 0 = register file, k+1 = slot k.
REQ-015 SHALL have port pipeline_stall_cnt  output  32  meaning the stall-cycle count (see Configuration).

Function
REQ-016 SHALL keep DEPTH slots, each holding {valid, rd, regwrite, is_load}; every cycle slot k shifts to k+1, and slot DEPTH-1 retires.
REQ-017 SHALL load slot 0 with the issuing instruction when issue_valid && !stall && !flush; otherwise it SHALL load a bubble (valid=0).
REQ-018 SHALL, for each source i, find the youngest (lowest k) valid slot with regwrite=1 and rd==rs_i; rs_i==0 SHALL never match.
REQ-019 SHALL drive fwd_sel_i=k+1 when a match exists and (!is_load || k>=LOAD_READY); otherwise it SHALL drive fwd_sel_i=0.
REQ-020 SHALL assert stall combinationally when issue_valid and any source's youngest match is a load with k<LOAD_READY.
REQ-021 SHALL let the youngest match win; an older non-load match behind a younger unready load SHALL still stall.
REQ-022 SHALL force stall=0 while flush=1; flush SHALL also invalidate slot 0 on the same edge.
REQ-023 SHALL give fwd_sel and stall zero latency (combinational from the inputs and current slots); the slots SHALL have one-cycle latency.
REQ-024 SHALL make stall independent of fwd_sel so that no combinational loop exists through issue_valid.

Reset
REQ-025 SHALL clear all slot valid bits on a reset edge; with no issue, stall=0, fwd_sel=0 and pipeline_stall_cnt=0 in the following cycle.
REQ-026 SHALL give reset priority over flush and issue; a reset during an active stall SHALL drop the stalled hazard.

Configuration
REQ-027 SHALL, with macro HAZARD_PERF_EN defined, count cycles with stall=1 in a 32-bit counter that saturates at 0xFFFFFFFF and is cleared by reset.
REQ-028 SHALL, without HAZARD_PERF_EN, tie pipeline_stall_cnt to 0 and instantiate no counter flops.

Structure
REQ-029 SHALL define the constant REG_ADDR_W=5, the slot struct and the FWD_RF=0 encoding in the shared package riscv_pkg.
REQ-030 SHALL use a single sub-module hazard_match, which is combinational and does per-source youngest-match priority, instantiated NUM_SRC times.

Verification
REQ-031 SHALL cover: issue add x5, then next cycle issue rs1=x5 -> fwd_sel_0=1, stall=0.
REQ-032 SHALL cover: issue lw x6, then next cycle issue rs2=x6 -> stall=1 for one cycle, then fwd_sel_1=2, stall=0.
REQ-033 SHALL cover: x7 written in slot 0 and slot 2, with rs1=x7 -> fwd_sel_0=1 (the youngest wins).
REQ-034 SHALL cover: rs1=x0 with slot 0 rd=x0 and regwrite=1 -> fwd_sel_0=0, stall=0.
REQ-035 SHALL cover: a load-use stall with flush=1 -> stall=0, and next cycle slot 0 is invalid.
REQ-036 SHALL cover, with HAZARD_PERF_EN: 3 load-use stalls, then reset -> pipeline_stall_cnt reads 3, then 0.
